// File: rtl/bcd_countdown.sv
// bcd_countdown: two-digit BCD down-counter stepped by rising edges of tick,
// with load/start control and a one-cycle done pulse on expiry.
module bcd_countdown (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] preset_tens,
    input  logic [3:0] preset_units,
    input  logic       start,
    input  logic       tick,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       busy,
    output logic       zero,
    output logic       done
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t     state, state_n;
    logic [3:0] tens_n, units_n;
    logic       done_n, tick_q, tick_rise;

    assign tick_rise = tick & ~tick_q;
    assign zero      = (tens == 4'd0) && (units == 4'd0);
    assign busy      = state == RUN;

    always_comb begin
        state_n = state;
        tens_n  = tens;
        units_n = units;
        done_n  = 1'b0;
        if (load) begin
            tens_n  = preset_tens  > 4'd9 ? 4'd9 : preset_tens;
            units_n = preset_units > 4'd9 ? 4'd9 : preset_units;
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: state_n = (start && !zero) ? RUN : IDLE;
                RUN: begin
                    // zero guard keeps the count from ever wrapping to 99
                    if (tick_rise && !zero) begin
                        units_n = units == 4'd0 ? 4'd9 : units - 4'd1;
                        tens_n  = units == 4'd0 ? tens - 4'd1 : tens;
                        if (tens == 4'd0 && units == 4'd1) begin
                            state_n = DONE;
                            done_n  = 1'b1;
                        end
                    end
                end
                DONE:    state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            tens   <= 4'd0;
            units  <= 4'd0;
            done   <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            state  <= state_n;
            tens   <= tens_n;
            units  <= units_n;
            done   <= done_n;
            tick_q <= tick;
        end
    end
endmodule

// File: tb/tb_bcd_countdown.sv
// tb_bcd_countdown: integer-count reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_bcd_countdown;
    logic       clk, reset, load, start, tick;
    logic [3:0] preset_tens, preset_units;
    logic [3:0] tens, units;
    logic       busy, zero, done;
    int         total = 0;
    int         bad = 0;

    bcd_countdown dut (
        .clk(clk), .reset(reset), .load(load),
        .preset_tens(preset_tens), .preset_units(preset_units),
        .start(start), .tick(tick),
        .tens(tens), .units(units), .busy(busy), .zero(zero), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: count as a plain integer 0..99
    int m_cnt;
    bit m_run, m_exp, m_done, m_prev, m_rise;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt = 0; m_run = 0; m_exp = 0; m_done = 0; m_prev = 0;
        end else begin
            m_rise = tick && !m_prev;
            m_prev = tick;
            m_done = 0;
            if (load) begin
                m_cnt = 10 * (preset_tens > 9 ? 9 : int'(preset_tens))
                      + (preset_units > 9 ? 9 : int'(preset_units));
                m_run = 0;
                m_exp = 0;
            end else if (m_run) begin
                if (m_rise) begin
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_run = 0; m_exp = 1; m_done = 1;
                    end
                end
            end else if (!m_exp && start && m_cnt != 0) begin
                m_run = 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_tens", int'(tens), m_cnt / 10);
        check("model_units", int'(units), m_cnt % 10);
        check("model_busy", int'(busy), int'(m_run));
        check("model_zero", int'(zero), int'(m_cnt == 0));
        check("model_done", int'(done), int'(m_done));
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_is(input string name, input int v);
        check(name, 10 * int'(tens) + int'(units), v);
    endtask

    task automatic do_load(input int t, input int u);
        load = 1; preset_tens = 4'(t); preset_units = 4'(u);
        cyc();
        load = 0;
    endtask

    int  cnt;
    bit  seen;

    initial begin
        reset = 0; load = 0; start = 0; tick = 0;
        preset_tens = 0; preset_units = 0;
        cyc(3);
        count_is("reset_count", 0);
        check("reset_busy", int'(busy), 0);
        check("reset_zero", int'(zero), 1);
        check("reset_done", int'(done), 0);
        reset = 1;
        cyc();

        // load, count and borrow
        do_load(2, 3);
        count_is("load_23", 23);
        check("load_busy", int'(busy), 0);
        start = 1; cyc(); start = 0;
        check("start_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick = 1; cyc();
            count_is("step_2x", 22 - i);
            tick = 0; cyc();
        end
        tick = 1; cyc(); tick = 0;
        count_is("borrow_19", 19);
        cyc();

        // expiry
        do_load(0, 2);
        start = 1; cyc(); start = 0;
        tick = 1; cyc(5);
        count_is("held_tick_01", 1);
        tick = 0; cyc();
        tick = 1; cyc();
        count_is("expire_00", 0);
        check("expire_done", int'(done), 1);
        check("expire_busy", int'(busy), 0);
        check("expire_zero", int'(zero), 1);
        tick = 0; cyc();
        check("done_one_cycle", int'(done), 0);
        repeat (3) begin
            tick = 1; cyc(); tick = 0; cyc();
        end
        count_is("no_wrap", 0);
        start = 1; cyc(2); start = 0;
        check("done_start_ignored", int'(busy), 0);

        // clamp and zero start
        do_load(12, 15);
        count_is("clamp_99", 99);
        do_load(0, 0);
        start = 1; cyc(3); start = 0;
        check("zero_start_busy", int'(busy), 0);
        check("zero_start_done", int'(done), 0);

        // priority
        do_load(5, 7);
        start = 1; cyc(); start = 0;
        check("run_57", int'(busy), 1);
        load = 1; tick = 1; preset_tens = 4; preset_units = 0;
        cyc();
        load = 0; tick = 0;
        count_is("load_over_tick", 40);
        check("load_over_tick_busy", int'(busy), 0);
        load = 1; start = 1; preset_tens = 3; preset_units = 5;
        cyc();
        load = 0;
        check("load_over_start", int'(busy), 0);
        cyc();
        check("start_after_load", int'(busy), 1);
        start = 0;

        // asynchronous reset mid-run
        #2 reset = 0;
        #1;
        count_is("async_reset_count", 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_done", int'(done), 0);
        tick = 1;
        cyc();
        reset = 1;
        cyc();
        do_load(0, 5);
        start = 1; cyc(); start = 0;
        cyc(3);
        count_is("held_tick_after_reset", 5);
        tick = 0; cyc();
        tick = 1; cyc();
        count_is("fresh_edge_step", 4);
        tick = 0;
        cyc();

        // continuous ticking from 99
        do_load(9, 9);
        start = 1; cyc(); start = 0;
        cnt = 0; seen = 0;
        while (!seen && cnt < 400) begin
            tick = ~tick;
            cyc();
            cnt++;
            seen = done;
            if (cnt == 20) count_is("toggle_rate", 89);
        end
        check("continuous_done_seen", int'(seen), 1);
        check("continuous_done_window", int'(cnt >= 197 && cnt <= 199), 1);
        tick = 0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
